// File: rtl/edge_rebuild.sv
// edge_rebuild: rebuilds a debounced level from single-cycle rise/fall/toggle
// request pulses, holding each new level for at least MIN_HIGH / MIN_LOW
// cycles. At most one transition is remembered while a hold runs (in tgt).
// Optional build macro EDGE_REBUILD_PULSE_OUT_EN adds the out_pos/out_neg
// one-cycle pulses that mark each change of lvl_out.
module edge_rebuild #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 8,
    parameter bit INIT_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rise_req,
    input  logic fall_req,
    input  logic tog_req,
    output logic lvl_out,
    output logic busy,
    output logic drop_err,
    output logic conflict_err
`ifdef EDGE_REBUILD_PULSE_OUT_EN
    ,
    output logic out_pos,
    output logic out_neg
`endif
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] HOLD_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] HOLD_LO = 2'd3;

    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(MIN_LOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             tgt;
    logic [1:0]       n_req;
    logic             multi_req;
    logic             next_tgt;

    // Decode this cycle's requests into the next target level
    always_comb begin
        n_req     = {1'b0, rise_req} + {1'b0, fall_req} + {1'b0, tog_req};
        multi_req = (n_req > 2'd1);
        next_tgt  = tgt;
        if (n_req == 2'd1) begin
            if (rise_req)
                next_tgt = 1'b1;
            else if (fall_req)
                next_tgt = 1'b0;
            else
                next_tgt = ~tgt;
        end
    end

    // A hold is running whenever the counter is non-zero
    assign busy = (cnt != '0);

    // Level FSM: idle states act on the target, hold states only count down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= INIT_LVL ? IDLE_HI : IDLE_LO;
            lvl_out      <= INIT_LVL;
            tgt          <= INIT_LVL;
            cnt          <= '0;
            drop_err     <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            tgt          <= next_tgt;
            conflict_err <= multi_req;
            drop_err     <= 1'b0;
            case (state)
                IDLE_LO: begin
                    if (next_tgt) begin
                        lvl_out <= 1'b1;
                        cnt     <= HI_LOAD;
                        state   <= (MIN_HIGH == 1) ? IDLE_HI : HOLD_HI;
                    end
                end
                IDLE_HI: begin
                    if (!next_tgt) begin
                        lvl_out <= 1'b0;
                        cnt     <= LO_LOAD;
                        state   <= (MIN_LOW == 1) ? IDLE_LO : HOLD_LO;
                    end
                end
                HOLD_HI, HOLD_LO: begin
                    // A request that returns the target to the held level
                    // cancels the remembered transition.
                    drop_err <= (next_tgt == lvl_out) && (tgt != lvl_out);
                    if (cnt > CNT_ONE) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        cnt   <= '0;
                        state <= (state == HOLD_HI) ? IDLE_HI : IDLE_LO;
                    end
                end
                default: begin
                    state <= lvl_out ? IDLE_HI : IDLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef EDGE_REBUILD_PULSE_OUT_EN
    // Mark the first cycle of each new level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_pos <= 1'b0;
            out_neg <= 1'b0;
        end else begin
            out_pos <= (state == IDLE_LO) && next_tgt;
            out_neg <= (state == IDLE_HI) && !next_tgt;
        end
    end
`endif

endmodule

// File: doc/edge_rebuild.md
Name: edge_rebuild

Overview:
Inverse of the team's edge detector: rebuilds a clean level signal from single-cycle edge-request pulses (rise, fall, toggle).
- Enforces a programmable minimum high time and minimum low time.
- Queues at most one pending transition while a hold interval runs.
- Flags swallowed glitches and conflicting requests.
- Sits between control logic that emits edge events and a pin or downstream block that needs a debounced level.

Parameters:
MIN_HIGH, 4, minimum cycles lvl_out stays 1 after rising (>=1)
MIN_LOW, 4, minimum cycles lvl_out stays 0 after falling (>=1)
CNT_W, 8, hold counter width; MIN_HIGH-1 and MIN_LOW-1 must fit
INIT_LVL, 0, lvl_out value after reset (0 or 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
rise_req  input  1  one-cycle pulse: drive level to 1
fall_req  input  1  one-cycle pulse: drive level to 0
tog_req  input  1  one-cycle pulse: invert target level
lvl_out  output  1  rebuilt level, registered
busy  output  1  1 while a minimum-time hold is running
drop_err  output  1  one-cycle pulse: pending transition cancelled (glitch swallowed)
conflict_err  output  1  one-cycle pulse: more than one request asserted in the same cycle

Behaviour:
- Reset (rst_n=0 sampled at a rising clk edge): lvl_out=INIT_LVL, tgt=INIT_LVL, cnt=0, state=IDLE_LO or IDLE_HI per INIT_LVL, busy=0, drop_err=0, conflict_err=0. Reset mid-hold aborts the hold and discards any pending request.
- Request decode (combinational, per cycle):
  - Exactly one request asserted: next_tgt = 1 (rise), 0 (fall), ~tgt (tog).
  - None asserted: next_tgt = tgt.
  - Two or more asserted: next_tgt = tgt, and conflict_err=1 on the next cycle.
- tgt <= next_tgt every cycle.
- FSM states: IDLE_LO, HOLD_HI, IDLE_HI, HOLD_LO.
  - IDLE_LO, next_tgt=1: lvl_out<=1, cnt<=MIN_HIGH-1, go to HOLD_HI (or IDLE_HI if MIN_HIGH=1).
  - IDLE_HI, next_tgt=0: lvl_out<=0, cnt<=MIN_LOW-1, go to HOLD_LO (or IDLE_LO if MIN_LOW=1).
  - HOLD_x: cnt decrements each cycle; lvl_out frozen; requests only update tgt. When cnt=1, go to IDLE_x (cnt becomes 0).
  - IDLE_x with tgt already != lvl_out (pending from hold): transition on that cycle's edge, same as a fresh request.
- Latency: a request in an idle state changes lvl_out at the next clock edge (1 cycle). A pending request takes effect at the edge closing the first idle cycle after the hold. lvl_out therefore stays high exactly MIN_HIGH cycles (low exactly MIN_LOW cycles) minimum.
- busy = (cnt != 0), registered with the state.
- drop_err: a request in HOLD_x that sets next_tgt == lvl_out while tgt != lvl_out (pending cancelled) gives drop_err=1 for one cycle, on the next cycle.
- Redundant requests (rise when tgt=1, fall when tgt=0): no effect, no error.
- Counter never wraps: it loads only on a transition and stops at 0.

Optional Feature:
EDGE_REBUILD_PULSE_OUT_EN
- Defined: adds outputs out_pos (1b) and out_neg (1b), registered one-cycle pulses asserted in the same cycle lvl_out first shows 1 (out_pos) or first shows 0 (out_neg). Both are 0 on reset; no pulse is generated by reset itself.
- Undefined: these ports and their logic are absent.

Test Plan:
1. MIN_HIGH=4, MIN_LOW=3, INIT_LVL=0; hold rst_n=0 for 3 cycles, then release -> lvl_out=0, busy=0, drop_err=0, conflict_err=0 throughout.
2. rise_req at cycle 10, fall_req at cycle 12 -> lvl_out=1 for cycles 11-14, busy=1 for cycles 11-13, lvl_out=0 from cycle 15, busy=1 for cycles 15-16, IDLE_LO at cycle 17.
3. rise_req at 10, fall_req at 11, rise_req at 12 -> lvl_out stays 1 from cycle 11 with no fall; drop_err=1 only at cycle 13.
4. rise_req and fall_req both at cycle 20, state IDLE_LO -> lvl_out stays 0; conflict_err=1 only at cycle 21; tgt unchanged.
5. rise_req at 10, rst_n=0 at cycle 12 only -> lvl_out=0, busy=0 at cycle 13; rise_req at 14 -> lvl_out=1 at cycle 15, busy=1 for cycles 15-17.
6. With EDGE_REBUILD_PULSE_OUT_EN defined, run scenario 2 -> out_pos=1 only at cycle 11, out_neg=1 only at cycle 15.
